mem_arbiter: RTL

Shares the single block-wide data memory between the data cache and the instruction cache refill/write-back paths. Each cache raises a request, and the arbiter grants one requester at a time. It drives the memory port for a fixed access latency, then returns the block with a one-cycle acknowledge. It sits between the two caches and the data memory, replacing direct cache-to-memory wiring.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates the shared block-wide data memory between the dcache and the icache.
// Latency: LATENCY cycles of memory access after the grant cycle, then a one-cycle ack (LATENCY+2 per access).
// Backpressure: requests are held until ack; requests seen outside IDLE are ignored until the next IDLE cycle.
//
// Ports:
//   clk_i, rst_n_i                               clock (rising edge), async active-low reset
//   d_req_i/d_we_i/d_addr_i/d_wdata_i, d_ack_o   dcache request side
//   i_req_i/i_we_i/i_addr_i/i_wdata_i, i_ack_o   icache request side
//   rdata_o                                      last read block, valid with ack
//   mem_addr_o/mem_read_o/mem_write_o/mem_wdata_o/mem_rdata_i   memory port
//   busy_o                                       high while ACCESS or DONE
// Optional feature: define MEM_ARB_RR_EN for round-robin tie-breaking (default: dcache fixed priority).

module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int BLK_W   = 32,
    parameter int LATENCY = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [BLK_W-1:0]  d_wdata_i,
    output logic              d_ack_o,

    input  logic              i_req_i,
    input  logic              i_we_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [BLK_W-1:0]  i_wdata_i,
    output logic              i_ack_o,

    output logic [BLK_W-1:0]  rdata_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [BLK_W-1:0]  mem_wdata_o,
    input  logic [BLK_W-1:0]  mem_rdata_i,

    output logic              busy_o
);

    localparam int CNT_W = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q;
    logic               gnt_i_q;   // 1: icache holds the current grant
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLK_W-1:0]   wdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BLK_W-1:0]   rdata_q;
    logic               d_ack_q;
    logic               i_ack_q;

    // Winner selection for the IDLE grant; only consumed in IDLE.
    logic               pick_i_d;

`ifdef MEM_ARB_RR_EN
    logic               last_i_q;  // 1: icache was granted last

    always_comb begin
        pick_i_d = 1'b0;
        if (i_req_i && d_req_i) begin
            pick_i_d = !last_i_q;
        end else begin
            pick_i_d = i_req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_i_q <= 1'b1;      // dcache wins the first tie
        end else if (state_q == DONE) begin
            last_i_q <= gnt_i_q;
        end
    end
`else
    always_comb begin
        pick_i_d = 1'b0;
        pick_i_d = i_req_i && !d_req_i;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_i_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            d_ack_q <= 1'b0;
            i_ack_q <= 1'b0;
        end else begin
            d_ack_q <= 1'b0;
            i_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_req_i || i_req_i) begin
                        gnt_i_q <= pick_i_d;
                        we_q    <= pick_i_d ? i_we_i    : d_we_i;
                        addr_q  <= pick_i_d ? i_addr_i  : d_addr_i;
                        wdata_q <= pick_i_d ? i_wdata_i : d_wdata_i;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        // Final access cycle: memory data is valid now.
                        if (!we_q) begin
                            rdata_q <= mem_rdata_i;
                        end
                        d_ack_q <= !gnt_i_q;
                        i_ack_q <= gnt_i_q;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Enables decode from registered state so reset drops them immediately.
    assign mem_read_o  = (state_q == ACCESS) && !we_q;
    assign mem_write_o = (state_q == ACCESS) &&  we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign d_ack_o     = d_ack_q;
    assign i_ack_o     = i_ack_q;
    assign busy_o      = (state_q == ACCESS) || (state_q == DONE);

endmodule
